// File: rtl/wb_pkg.sv
// Shared constants for the writeback-select stage.
//   WB_SRC_*  : writeback source slot indices inside src_data
//   F3_*      : load funct3 codes understood by the load extender
package wb_pkg;

  localparam int unsigned WB_SRC_ALU = 0;
  localparam int unsigned WB_SRC_MEM = 1;
  localparam int unsigned WB_SRC_PC4 = 2;
  localparam int unsigned WB_SRC_IMM = 3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Combinational load aligner/extender for the Memoria writeback source.
// Ports:
//   word     in  XLEN  raw memory word
//   funct3   in  3     load type (LB/LH/LW/LBU/LHU)
//   byte_off in  2     load address [1:0]
//   ext      out XLEN  aligned and sign/zero-extended result
// Codes other than byte/half loads pass the word through unchanged.
module load_extend
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (byte_off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    // Halfword alignment ignores byte_off[0].
    half_sel = byte_off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_sel};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/wb_select_stage.sv
// MEM/WB pipeline stage: selects one of NSRC writeback sources and registers it,
// with stall/flush control, x0 write guard and a retired-instruction counter.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid, stall, flush  stage control (priority rst > flush > stall > capture)
//   WbSel                 source select; out-of-range selects 0
//   src_data              packed sources, slot k = [k*XLEN +: XLEN]
//   rd_in, RegWrite_in    destination register and write request
//   funct3, byte_off      load type/offset (only used with WB_LOAD_EXT_EN)
//   out_valid, out_wb_data, out_rd, out_we  registered stage outputs
//   retire_cnt            count of valid captures, wraps modulo 2**CNTW
// Configuration macro: WB_LOAD_EXT_EN enables load alignment/extension of the
// Memoria source; when undefined the Memoria word passes unchanged.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NSRC = 4,
  parameter int unsigned SELW = 2,
  parameter int unsigned CNTW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [SELW-1:0]      WbSel,
  input  logic [NSRC*XLEN-1:0] src_data,
  input  logic [4:0]           rd_in,
  input  logic                 RegWrite_in,
  input  logic [2:0]           funct3,
  input  logic [1:0]           byte_off,
  output logic                 out_valid,
  output logic [XLEN-1:0]      out_wb_data,
  output logic [4:0]           out_rd,
  output logic                 out_we,
  output logic [CNTW-1:0]      retire_cnt
);

  logic [XLEN-1:0] sel_data;

`ifdef WB_LOAD_EXT_EN
  logic [XLEN-1:0] mem_ext;

  load_extend #(
    .XLEN (XLEN)
  ) u_load_extend (
    .word     (src_data[WB_SRC_MEM*XLEN +: XLEN]),
    .funct3   (funct3),
    .byte_off (byte_off),
    .ext      (mem_ext)
  );
`else
  logic unused_load_ctrl;
  assign unused_load_ctrl = ^{funct3, byte_off};
`endif

  // No slot matches when WbSel >= NSRC, leaving the zero default.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (WbSel == SELW'(k)) begin
        sel_data = src_data[k*XLEN +: XLEN];
      end
    end
`ifdef WB_LOAD_EXT_EN
    if (WbSel == SELW'(WB_SRC_MEM)) begin
      sel_data = mem_ext;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_wb_data <= '0;
      out_rd      <= '0;
      out_we      <= 1'b0;
      retire_cnt  <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_wb_data <= '0;
      out_rd      <= '0;
      out_we      <= 1'b0;
    end else if (!stall) begin
      out_valid   <= in_valid;
      out_wb_data <= sel_data;
      out_rd      <= rd_in;
      // Writes to x0 are suppressed so the register file never sees them.
      out_we      <= in_valid & RegWrite_in & (rd_in != 5'd0);
      if (in_valid) begin
        retire_cnt <= retire_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_select_stage.sv
module tb_wb_select_stage;

  logic         clk = 1'b0;
  logic         rst, in_valid, stall, flush, reg_write;
  logic [1:0]   wb_sel;
  logic [127:0] src;
  logic [4:0]   rd_in;
  logic [2:0]   funct3;
  logic [1:0]   byte_off;

  logic         a_valid, a_we, b_valid, b_we;
  logic [31:0]  a_data, b_data, a_cnt;
  logic [4:0]   a_rd, b_rd;
  logic [3:0]   b_cnt;

  int total = 0;
  int bad = 0;

  // Reference state
  logic        m_valid, m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_adata, m_bdata;
  longint      m_acnt, m_bcnt;

  always #5 clk = ~clk;

  wb_select_stage dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .WbSel(wb_sel), .src_data(src), .rd_in(rd_in), .RegWrite_in(reg_write),
    .funct3(funct3), .byte_off(byte_off), .out_valid(a_valid), .out_wb_data(a_data),
    .out_rd(a_rd), .out_we(a_we), .retire_cnt(a_cnt)
  );

  wb_select_stage #(.XLEN(32), .NSRC(3), .SELW(2), .CNTW(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .WbSel(wb_sel), .src_data(src[95:0]), .rd_in(rd_in), .RegWrite_in(reg_write),
    .funct3(funct3), .byte_off(byte_off), .out_valid(b_valid), .out_wb_data(b_data),
    .out_rd(b_rd), .out_we(b_we), .retire_cnt(b_cnt)
  );

  function automatic logic [31:0] load_ref(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [127:0] s, input int ws, input int n,
                                       input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] w;
    if (ws >= n) return 32'h0;
    w = s[ws*32 +: 32];
`ifdef WB_LOAD_EXT_EN
    if (ws == 1) w = load_ref(w, f3, off);
`endif
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    if (rst) begin
      m_valid = 0; m_we = 0; m_rd = 0; m_adata = 0; m_bdata = 0; m_acnt = 0; m_bcnt = 0;
    end else if (flush) begin
      m_valid = 0; m_we = 0; m_rd = 0; m_adata = 0; m_bdata = 0;
    end else if (!stall) begin
      m_valid = in_valid;
      m_rd    = rd_in;
      m_we    = in_valid && reg_write && (rd_in != 0);
      m_adata = pick(src, int'(wb_sel), 4, funct3, byte_off);
      m_bdata = pick(src, int'(wb_sel), 3, funct3, byte_off);
      if (in_valid) begin
        m_acnt = (m_acnt + 1) % 64'h1_0000_0000;
        m_bcnt = (m_bcnt + 1) % 16;
      end
    end
    @(posedge clk);
    #1;
    chk("valid", {31'b0, a_valid}, {31'b0, m_valid});
    chk("we", {31'b0, a_we}, {31'b0, m_we});
    chk("rd", {27'b0, a_rd}, {27'b0, m_rd});
    chk("data", a_data, m_adata);
    chk("cnt", a_cnt, 32'(m_acnt));
    chk("s_valid", {31'b0, b_valid}, {31'b0, m_valid});
    chk("s_we", {31'b0, b_we}, {31'b0, m_we});
    chk("s_rd", {27'b0, b_rd}, {27'b0, m_rd});
    chk("s_data", b_data, m_bdata);
    chk("s_cnt", {28'b0, b_cnt}, 32'(m_bcnt));
  endtask

  task automatic idle();
    rst = 0; flush = 0; stall = 0; in_valid = 1; reg_write = 1; rd_in = 5'd5;
    wb_sel = 2'd0; funct3 = 3'b010; byte_off = 2'd0;
  endtask

  initial begin
    m_valid = 0; m_we = 0; m_rd = 0; m_adata = 0; m_bdata = 0; m_acnt = 0; m_bcnt = 0;

    // 1: reset with every input nonzero
    rst = 1; in_valid = 1; stall = 1; flush = 1; reg_write = 1; wb_sel = 2'd3;
    src = {4{32'hDEAD_BEEF}}; rd_in = 5'd7; funct3 = 3'd5; byte_off = 2'd3;
    step(); step();
    chk("rst_data", a_data, 32'h0);
    chk("rst_cnt", a_cnt, 32'h0);

    // 2: ALU then Memoria
    idle();
    src = {32'h0000_0003, 32'h0000_0002, 32'h7FFF_FFFF, 32'h1234_5678};
    step();
    chk("t2_alu", a_data, 32'h1234_5678);
    wb_sel = 2'd1;
    step();
    chk("t2_mem", a_data, 32'h7FFF_FFFF);
    chk("t2_we", {31'b0, a_we}, 32'h1);
    chk("t2_cnt", a_cnt, 32'd2);

    // 3: x0 guard and out-of-range select on the 3-source instance
    rd_in = 5'd0; wb_sel = 2'd3;
    step();
    chk("t3_we", {31'b0, a_we}, 32'h0);
    chk("t3_valid", {31'b0, a_valid}, 32'h1);
    chk("t3_sel", b_data, 32'h0);

    // 4: stall with changing inputs, then stall+flush
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      src = {$urandom, $urandom, $urandom, $urandom};
      wb_sel = 2'($urandom); rd_in = 5'($urandom);
      step();
    end
    flush = 1;
    step();
    chk("t4_flush", a_data, 32'h0);

    // 5: load extension cases (model selects config-dependent result)
    idle();
    src = {32'h0000_0003, 32'h0000_0002, 32'h80F0_7F81, 32'h0000_0001};
    wb_sel = 2'd1;
    funct3 = 3'b000; byte_off = 2'd0; step();
    funct3 = 3'b100; byte_off = 2'd0; step();
    funct3 = 3'b000; byte_off = 2'd1; step();
    funct3 = 3'b001; byte_off = 2'd2; step();
    funct3 = 3'b101; byte_off = 2'd2; step();
    funct3 = 3'b001; byte_off = 2'd3; step();
    funct3 = 3'b110; byte_off = 2'd1; step();

    // 6: counter wrap on the CNTW=4 instance, then reset mid-stream
    rst = 1; step();
    idle();
    for (int i = 0; i < 17; i++) begin
      src = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    chk("t6_wrap", {28'b0, b_cnt}, 32'd1);
    rst = 1; step();
    chk("t6_rst_valid", {31'b0, a_valid}, 32'h0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      stall     = ($urandom_range(0, 5) == 0);
      in_valid  = 1'($urandom);
      reg_write = 1'($urandom);
      wb_sel    = 2'($urandom);
      src       = {$urandom, $urandom, $urandom, $urandom};
      rd_in     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      funct3    = 3'($urandom);
      byte_off  = 2'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
